// File: rtl/multicycle_controller.sv
// Multicycle RV32 control FSM with a ready-wait timeout trap.
// Define MULDIV_EN to sequence an external multicycle mul/div unit.
module multicycle_controller #(
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [6:0] inst_opcode,
   input  logic [6:0] inst_funct7,
   input  logic       imem_ready,
   input  logic       dmem_ready,
   input  logic       muldiv_done,
   output logic       imem_req,
   output logic       ir_write,
   output logic       pc_write,
   output logic       dmem_req,
   output logic       dmem_write,
   output logic       reg_write,
   output logic       muldiv_start,
   output logic [2:0] state,
   output logic       trap
);

   typedef enum logic [2:0] {
      S_FETCH   = 3'd0,
      S_DECODE  = 3'd1,
      S_EXECUTE = 3'd2,
      S_MEMORY  = 3'd3,
      S_WB      = 3'd4,
      S_TRAP    = 3'd5,
      S_BAD6    = 3'd6,
      S_BAD7    = 3'd7
   } state_e;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_MISC   = 7'b0001111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   localparam logic [15:0] TMO = 16'(MEM_TIMEOUT);

   state_e      state_q, state_d;
   logic [15:0] wait_q, wait_d, wait_inc;
   logic        busy_q, busy_d;
   logic        timeout;
   logic        legal, is_load, is_store, is_ctl, is_mul;

   always_comb begin
      legal = 1'b0;
      case (inst_opcode)
         OP_LOAD, OP_STORE, OP_OP, OP_IMM, OP_LUI, OP_AUIPC,
         OP_JAL, OP_JALR, OP_BRANCH, OP_MISC, OP_SYSTEM:
            legal = 1'b1;
         default:
            legal = 1'b0;
      endcase
   end

   assign is_load  = (inst_opcode == OP_LOAD);
   assign is_store = (inst_opcode == OP_STORE);
   assign is_ctl   = (inst_opcode == OP_BRANCH) |
                     (inst_opcode == OP_MISC) |
                     (inst_opcode == OP_SYSTEM);

`ifdef MULDIV_EN
   assign is_mul = (inst_opcode == OP_OP) &&
                   (inst_funct7 == 7'b0000001);
`else
   // funct7 only matters for M-extension sequencing
   logic unused_funct7;
   assign unused_funct7 = ^inst_funct7;
   assign is_mul        = 1'b0;
`endif

   // Saturating wait counter; cleared on every state change
   assign wait_inc = (wait_q == 16'hFFFF) ? wait_q : wait_q + 16'd1;
   assign timeout  = (wait_q >= TMO);

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_FETCH;
         wait_q  <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         busy_q  <= busy_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      wait_d       = wait_q;
      busy_d       = busy_q;
      imem_req     = 1'b0;
      ir_write     = 1'b0;
      pc_write     = 1'b0;
      dmem_req     = 1'b0;
      dmem_write   = 1'b0;
      reg_write    = 1'b0;
      muldiv_start = 1'b0;
      trap         = 1'b0;

      unique case (state_q)
         S_FETCH: begin
            imem_req = 1'b1;
            if (imem_ready) begin
               ir_write = 1'b1;
               state_d  = S_DECODE;
            end else if (timeout) begin
               state_d = S_TRAP;
            end else begin
               wait_d = wait_inc;
            end
         end
         S_DECODE: begin
            state_d = legal ? S_EXECUTE : S_TRAP;
         end
         S_EXECUTE: begin
            unique case (1'b1)
               is_mul: begin
                  // done is only meaningful after the start pulse
                  muldiv_start = !busy_q;
                  busy_d       = 1'b1;
                  if (busy_q && muldiv_done) begin
                     state_d = S_WB;
                  end else if (timeout) begin
                     state_d = S_TRAP;
                  end else begin
                     wait_d = wait_inc;
                  end
               end
               is_load | is_store: begin
                  state_d = S_MEMORY;
               end
               is_ctl: begin
                  pc_write = 1'b1;
                  state_d  = S_FETCH;
               end
               default: begin
                  state_d = S_WB;
               end
            endcase
         end
         S_MEMORY: begin
            dmem_req   = 1'b1;
            dmem_write = is_store;
            if (dmem_ready) begin
               if (is_store) begin
                  pc_write = 1'b1;
                  state_d  = S_FETCH;
               end else begin
                  state_d = S_WB;
               end
            end else if (timeout) begin
               state_d = S_TRAP;
            end else begin
               wait_d = wait_inc;
            end
         end
         S_WB: begin
            reg_write = 1'b1;
            pc_write  = 1'b1;
            state_d   = S_FETCH;
         end
         S_TRAP: begin
            trap = 1'b1;
         end
         S_BAD6, S_BAD7: begin
            state_d = S_TRAP;
         end
         default: begin
            state_d = S_TRAP;
         end
      endcase

      if (state_d != state_q) begin
         wait_d = '0;
      end
      if (state_d != S_EXECUTE) begin
         busy_d = 1'b0;
      end

      // Nothing is requested or written while reset is held
      if (reset) begin
         imem_req     = 1'b0;
         ir_write     = 1'b0;
         pc_write     = 1'b0;
         dmem_req     = 1'b0;
         dmem_write   = 1'b0;
         reg_write    = 1'b0;
         muldiv_start = 1'b0;
         trap         = 1'b0;
      end
   end

   assign state = state_q;

endmodule
